// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 serial pattern detector.
package seq_pkg;

   localparam int unsigned STATE_W = 3;
   localparam logic [3:0]  PATTERN = 4'b1011;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE = 3'd0,
      S_1    = 3'd1,
      S_10   = 3'd2,
      S_101  = 3'd3,
      S_1011 = 3'd4
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky overflow flag and synchronous clear.
module sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Clear takes priority over a coincident increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (inc) begin
         if (cnt == CNT_MAX) begin
            ovf <= 1'b1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/seq_detect_1011.sv
// Moore detector for the serial pattern 1-0-1-1 with hit counting and bit history.
module seq_detect_1011
   import seq_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               din,
   input  logic               din_valid,
   input  logic               overlap_en,
   input  logic               clr_cnt,
   output logic               detect,
   output logic [STATE_W-1:0] state_out,
   output logic [3:0]         hist,
   output logic [CNT_W-1:0]   hit_cnt,
   output logic               cnt_ovf
);

   state_t state;
   state_t state_nxt;
   logic   hit_c;

   // Next state; only accepted bits advance, unused encodings fall back to idle.
   always_comb begin
      state_nxt = state;
      hit_c     = 1'b0;
      case (state)
         S_IDLE: if (din_valid) state_nxt = din ? S_1 : S_IDLE;
         S_1:    if (din_valid) state_nxt = din ? S_1 : S_10;
         S_10:   if (din_valid) state_nxt = din ? S_101 : S_IDLE;
         S_101: begin
            if (din_valid) begin
               state_nxt = din ? S_1011 : S_10;
               hit_c     = din;
            end
         end
         S_1011: begin
            if (din_valid) begin
               if (din) state_nxt = S_1;
               else     state_nxt = overlap_en ? S_10 : S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         detect <= 1'b0;
         hist   <= 4'b0000;
      end else begin
         state  <= state_nxt;
         detect <= hit_c;
         if (din_valid) begin
            hist <= {hist[2:0], din};
         end
      end
   end

   assign state_out = state;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_hit_cnt (
      .clk (clk),
      .rst (rst),
      .inc (hit_c),
      .clr (clr_cnt),
      .cnt (hit_cnt),
      .ovf (cnt_ovf)
   );

endmodule

// File: tb/tb_seq_detect_1011.sv
// Directed bench for seq_detect_1011: vector table plus hand-written corner sequences.
module tb_seq_detect_1011;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       overlap_en = 1'b1;
   logic       clr_cnt = 1'b0;

   logic       detect, detect2;
   logic [2:0] state_out, state_out2;
   logic [3:0] hist, hist2;
   logic [7:0] hit_cnt;
   logic [1:0] hit_cnt2;
   logic       cnt_ovf, cnt_ovf2;

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   seq_detect_1011 #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .overlap_en(overlap_en), .clr_cnt(clr_cnt),
      .detect(detect), .state_out(state_out), .hist(hist),
      .hit_cnt(hit_cnt), .cnt_ovf(cnt_ovf)
   );

   seq_detect_1011 #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .overlap_en(overlap_en), .clr_cnt(clr_cnt),
      .detect(detect2), .state_out(state_out2), .hist(hist2),
      .hit_cnt(hit_cnt2), .cnt_ovf(cnt_ovf2)
   );

   typedef struct {
      logic       rst_b;
      logic       v;
      logic       d;
      logic       ov;
      logic       clr;
      logic       det;
      logic [2:0] st;
      logic [3:0] hist;
      logic [7:0] cnt;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; din_valid = 1'b0; din = 1'b0; clr_cnt = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Drive on the falling edge, sample just after the following rising edge.
   task automatic step(input logic v, input logic d, input logic ov, input logic clr);
      @(negedge clk);
      din_valid = v; din = d; overlap_en = ov; clr_cnt = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [12:0] sat_bits;

      // rst, v, d, ov, clr | det, state, hist, cnt
      // Overlapping 1011011
      vq.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 4'b0001, 8'd0});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 4'b0010, 8'd0});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'b0101, 8'd0});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 4'b1011, 8'd1});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 4'b0110, 8'd1});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'b1101, 8'd1});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 4'b1011, 8'd2});
      // Non-overlapping 1011011
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'b0111, 8'd2});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'b1110, 8'd2});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 4'b1101, 8'd2});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 4'b1011, 8'd3});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0110, 8'd3});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'b1101, 8'd3});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'b1011, 8'd3});
      // 1011 then 1011, overlap_en toggled outside S_1011 has no effect
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 4'b0111, 8'd3});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'b1110, 8'd3});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'b1101, 8'd3});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 4'b1011, 8'd4});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0110, 8'd4});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'b1101, 8'd4});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'b1010, 8'd4});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 4'b0101, 8'd4});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 4'b1011, 8'd5});
      vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 4'b1011, 8'd5});
      // Near-miss 1010 1011
      vq.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 4'b0001, 8'd0});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 4'b0010, 8'd0});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'b0101, 8'd0});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 4'b1010, 8'd0});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'b0101, 8'd0});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 4'b1010, 8'd0});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'b0101, 8'd0});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 4'b1011, 8'd1});

      // Power-on reset state
      do_reset();
      #1;
      chk("por_detect", 32'(detect), 32'd0);
      chk("por_state", 32'(state_out), 32'd0);
      chk("por_hist", 32'(hist), 32'd0);
      chk("por_cnt", 32'(hit_cnt), 32'd0);
      chk("por_ovf", 32'(cnt_ovf), 32'd0);

      for (int i = 0; i < vq.size(); i++) begin
         if (vq[i].rst_b) do_reset();
         step(vq[i].v, vq[i].d, vq[i].ov, vq[i].clr);
         chk($sformatf("vec%0d_detect", i), 32'(detect), 32'(vq[i].det));
         chk($sformatf("vec%0d_state", i), 32'(state_out), 32'(vq[i].st));
         chk($sformatf("vec%0d_hist", i), 32'(hist), 32'(vq[i].hist));
         chk($sformatf("vec%0d_cnt", i), 32'(hit_cnt), 32'(vq[i].cnt));
      end

      // Stall mid-pattern and again inside S_1011: no extra pulse, state and history hold
      do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'(i), 1'b1, 1'b0);
         chk($sformatf("stall_a%0d_detect", i), 32'(detect), 32'd0);
         chk($sformatf("stall_a%0d_hist", i), 32'(hist), 32'b0101);
         chk($sformatf("stall_a%0d_state", i), 32'(state_out), 32'd3);
      end
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("stall_hit_detect", 32'(detect), 32'd1);
      chk("stall_hit_hist", 32'(hist), 32'b1011);
      chk("stall_hit_cnt", 32'(hit_cnt), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'(~i), 1'b0, 1'b0);
         chk($sformatf("stall_b%0d_detect", i), 32'(detect), 32'd0);
         chk($sformatf("stall_b%0d_hist", i), 32'(hist), 32'b1011);
         chk($sformatf("stall_b%0d_state", i), 32'(state_out), 32'd4);
      end
      chk("stall_cnt_hold", 32'(hit_cnt), 32'd1);

      // Asynchronous reset mid-pattern discards the partial match
      do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      din_valid = 1'b1; din = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("arst_state", 32'(state_out), 32'd0);
      chk("arst_hist", 32'(hist), 32'd0);
      chk("arst_detect", 32'(detect), 32'd0);
      @(posedge clk);
      #1;
      chk("arst_no_pulse", 32'(detect), 32'd0);
      chk("arst_hold_state", 32'(state_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("arst_first_accept_state", 32'(state_out), 32'd1);
      chk("arst_first_accept_detect", 32'(detect), 32'd0);

      // Saturation on the 2-bit counter, then clear racing a hit
      do_reset();
      sat_bits = 13'b1011011011011;
      for (int i = 12; i >= 0; i--) begin
         step(1'b1, sat_bits[i], 1'b1, 1'b0);
         if (i == 3) begin
            chk("sat3_cnt2", 32'(hit_cnt2), 32'd3);
            chk("sat3_ovf2", 32'(cnt_ovf2), 32'd0);
         end
      end
      chk("sat4_detect", 32'(detect2), 32'd1);
      chk("sat4_cnt2", 32'(hit_cnt2), 32'd3);
      chk("sat4_ovf2", 32'(cnt_ovf2), 32'd1);
      chk("sat4_cnt8", 32'(hit_cnt), 32'd4);
      chk("sat4_ovf8", 32'(cnt_ovf), 32'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("sat_sticky_ovf2", 32'(cnt_ovf2), 32'd1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("clrhit_detect", 32'(detect2), 32'd1);
      chk("clrhit_cnt2", 32'(hit_cnt2), 32'd0);
      chk("clrhit_ovf2", 32'(cnt_ovf2), 32'd0);
      chk("clrhit_cnt8", 32'(hit_cnt), 32'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("post_clr_cnt2", 32'(hit_cnt2), 32'd1);
      chk("post_clr_detect", 32'(detect2), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
